// File: rtl/mdl_pgcntr_pkg.sv
// Shared constants for the serial page counter.
//   DefWidth   : default counter width in bits
//   DefModulus : default page-count modulus
//   DefStep    : default per-frame increment
//   dir_e      : count direction encoding (up adds STEP, down subtracts STEP)
package mdl_pgcntr_pkg;

    localparam int unsigned     DefWidth   = 12;
    localparam longint unsigned DefModulus = 2053;
    localparam longint unsigned DefStep    = 522;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

endpackage

// File: rtl/mdl_serpgcntr_fa.sv
// One-bit full adder cell used as the serial adder of the page counter.
//   a_i, b_i, c_i : addend bits and carry in
//   s_o           : sum bit
//   co_o          : carry out
module mdl_serpgcntr_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/mdl_serpgcntr.sv
// Bit-serial modulo page counter.
// Each frame is WIDTH+1 clock-enabled ticks. Slots 0..WIDTH-1 add the per-frame
// constant K to the value one bit at a time (LSB first) through a full-adder cell;
// slot WIDTH commits the result, applies pending controls and precomputes whether
// the next frame needs the modulus-corrected constant.
//   i_MCLK         : master clock
//   i_RST          : synchronous active-high reset
//   i_CLK2M_PCEN_n : tick enable, active low
//   i_CNT_START    : set pending enable
//   i_CNT_STOP     : clear pending enable (wins over start)
//   i_DIR          : 0 = up, 1 = down, sampled at the frame boundary
//   i_LOAD         : capture i_LOAD_VAL for the next frame boundary
//   i_LOAD_VAL     : preload value
//   o_SER_LSB      : serial sum bit (0 in slot WIDTH)
//   o_VALUE        : committed counter value
//   o_FRAME_END    : one-tick pulse after each frame boundary
//   o_WRAP         : one-tick pulse when the corrected constant was used
//   o_LOAD_ERR     : one-tick pulse when an out-of-range load was dropped
module mdl_serpgcntr
    import mdl_pgcntr_pkg::*;
#(
    parameter int unsigned     WIDTH   = DefWidth,
    parameter longint unsigned MODULUS = DefModulus,
    parameter longint unsigned STEP    = DefStep
) (
    input  logic             i_MCLK,
    input  logic             i_RST,
    input  logic             i_CLK2M_PCEN_n,
    input  logic             i_CNT_START,
    input  logic             i_CNT_STOP,
    input  logic             i_DIR,
    input  logic             i_LOAD,
    input  logic [WIDTH-1:0] i_LOAD_VAL,
    output logic             o_SER_LSB,
    output logic [WIDTH-1:0] o_VALUE,
    output logic             o_FRAME_END,
    output logic             o_WRAP,
    output logic             o_LOAD_ERR
);

    // Parameter legality
    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("mdl_serpgcntr: WIDTH must be in 4..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("mdl_serpgcntr: MODULUS must be in 2..2**WIDTH");
    end
    if (STEP == 0 || STEP >= MODULUS) begin : g_bad_step
        $error("mdl_serpgcntr: STEP must be in 1..MODULUS-1");
    end

    localparam int unsigned     SlotW    = $clog2(WIDTH + 1);
    localparam logic [SlotW-1:0] LastSlot = SlotW'(WIDTH);
    localparam logic [63:0]     Mod64    = 64'(MODULUS);
    localparam logic [63:0]     Step64   = 64'(STEP);
    localparam logic [63:0]     UpThresh = Mod64 - Step64;

    // Per-frame constants, all taken mod 2**WIDTH
    localparam logic [WIDTH-1:0] KUp     = WIDTH'(Step64);
    localparam logic [WIDTH-1:0] KUpWrap = WIDTH'(Step64 - Mod64);
    localparam logic [WIDTH-1:0] KDn     = WIDTH'(64'd0 - Step64);
    localparam logic [WIDTH-1:0] KDnWrap = WIDTH'(Mod64 - Step64);

    logic             tick;
    logic             last_slot;

    logic [SlotW-1:0] slot_q, slot_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             en_act_q, en_act_d;
    logic             en_pend_q, en_pend_d;
    dir_e             dir_act_q, dir_act_d;
    logic             load_pend_q, load_pend_d;
    logic [WIDTH-1:0] load_val_q, load_val_d;
    logic             wrap_flag_q, wrap_flag_d;
    logic             frame_end_q, frame_end_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH-1:0] k_sel;
    logic             k_bit;
    logic             sum_bit;
    logic             carry_out;
    logic             load_ok;
    logic             load_apply;
    logic [WIDTH-1:0] new_val;
    dir_e             dir_in;

    assign tick      = ~i_CLK2M_PCEN_n;
    assign last_slot = (slot_q == LastSlot);
    assign dir_in    = dir_e'(i_DIR);

    // Constant selection for the frame in progress
    always_comb begin
        k_sel = '0;
        if (en_act_q) begin
            if (dir_act_q == DirUp) begin
                k_sel = wrap_flag_q ? KUpWrap : KUp;
            end else begin
                k_sel = wrap_flag_q ? KDnWrap : KDn;
            end
        end
    end

    // Bit of K for the current slot; mux avoids an index-width mismatch
    always_comb begin
        k_bit = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (slot_q == SlotW'(i)) begin
                k_bit = k_sel[i];
            end
        end
    end

    mdl_serpgcntr_fa u_fa (
        .a_i  (sr_q[0]),
        .b_i  (k_bit),
        .c_i  (carry_q),
        .s_o  (sum_bit),
        .co_o (carry_out)
    );

    assign load_ok    = (64'(load_val_q) < Mod64);
    assign load_apply = load_pend_q & load_ok;
    assign new_val    = load_apply ? load_val_q : sr_q;

    always_comb begin
        slot_d      = slot_q;
        carry_d     = carry_q;
        sr_d        = sr_q;
        value_d     = value_q;
        en_act_d    = en_act_q;
        en_pend_d   = en_pend_q;
        dir_act_d   = dir_act_q;
        load_pend_d = load_pend_q;
        load_val_d  = load_val_q;
        wrap_flag_d = wrap_flag_q;
        frame_end_d = frame_end_q;
        wrap_d      = wrap_q;
        load_err_d  = load_err_q;

        if (tick) begin
            frame_end_d = 1'b0;
            wrap_d      = 1'b0;
            load_err_d  = 1'b0;

            if (i_CNT_STOP) begin
                en_pend_d = 1'b0;
            end else if (i_CNT_START) begin
                en_pend_d = 1'b1;
            end

            if (last_slot) begin
                slot_d      = '0;
                carry_d     = 1'b0;
                sr_d        = new_val;
                value_d     = new_val;
                frame_end_d = 1'b1;
                wrap_d      = en_act_q & wrap_flag_q & ~load_apply;
                load_err_d  = load_pend_q & ~load_ok;
                en_act_d    = en_pend_q;
                dir_act_d   = dir_in;
                load_pend_d = 1'b0;
                // Decide now whether the next frame would leave 0..MODULUS-1
                if (dir_in == DirUp) begin
                    wrap_flag_d = (64'(new_val) >= UpThresh);
                end else begin
                    wrap_flag_d = (64'(new_val) < Step64);
                end
            end else begin
                slot_d  = slot_q + 1'b1;
                carry_d = carry_out;
                sr_d    = {sum_bit, sr_q[WIDTH-1:1]};
            end

            // A load seen on the boundary tick itself waits for the next boundary
            if (i_LOAD) begin
                load_pend_d = 1'b1;
                load_val_d  = i_LOAD_VAL;
            end
        end
    end

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            slot_q      <= '0;
            carry_q     <= 1'b0;
            sr_q        <= '0;
            value_q     <= '0;
            en_act_q    <= 1'b0;
            en_pend_q   <= 1'b0;
            dir_act_q   <= DirUp;
            load_pend_q <= 1'b0;
            load_val_q  <= '0;
            wrap_flag_q <= 1'b0;
            frame_end_q <= 1'b0;
            wrap_q      <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            carry_q     <= carry_d;
            sr_q        <= sr_d;
            value_q     <= value_d;
            en_act_q    <= en_act_d;
            en_pend_q   <= en_pend_d;
            dir_act_q   <= dir_act_d;
            load_pend_q <= load_pend_d;
            load_val_q  <= load_val_d;
            wrap_flag_q <= wrap_flag_d;
            frame_end_q <= frame_end_d;
            wrap_q      <= wrap_d;
            load_err_q  <= load_err_d;
        end
    end

    assign o_SER_LSB   = last_slot ? 1'b0 : sum_bit;
    assign o_VALUE     = value_q;
    assign o_FRAME_END = frame_end_q;
    assign o_WRAP      = wrap_q;
    assign o_LOAD_ERR  = load_err_q;

endmodule

// File: tb/tb_mdl_serpgcntr.sv
// Directed bench for mdl_serpgcntr with default parameters (12 bits, mod 2053, step 522).
module tb_mdl_serpgcntr;

    logic        clk;
    logic        rst;
    logic        pcen_n;
    logic        cnt_start;
    logic        cnt_stop;
    logic        dir;
    logic        load;
    logic [11:0] load_val;
    logic        ser_lsb;
    logic [11:0] value;
    logic        frame_end;
    logic        wrap;
    logic        load_err;

    int tests = 0;
    int fails = 0;

    mdl_serpgcntr dut (
        .i_MCLK         (clk),
        .i_RST          (rst),
        .i_CLK2M_PCEN_n (pcen_n),
        .i_CNT_START    (cnt_start),
        .i_CNT_STOP     (cnt_stop),
        .i_DIR          (dir),
        .i_LOAD         (load),
        .i_LOAD_VAL     (load_val),
        .o_SER_LSB      (ser_lsb),
        .o_VALUE        (value),
        .o_FRAME_END    (frame_end),
        .o_WRAP         (wrap),
        .o_LOAD_ERR     (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned obs,
                         input longint unsigned exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to the next frame-end pulse (bounded) and check value / wrap / load error
    task automatic frame(input string tag, input int exp_val, input bit exp_wrap,
                         input bit exp_lerr);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_end && n < 40);
        check({tag, "_fe"}, frame_end, 1);
        check({tag, "_val"}, value, exp_val);
        check({tag, "_wrap"}, wrap, exp_wrap);
        check({tag, "_lerr"}, load_err, exp_lerr);
    endtask

    initial begin
        rst       = 1'b1;
        pcen_n    = 1'b0;
        cnt_start = 1'b0;
        cnt_stop  = 1'b0;
        dir       = 1'b0;
        load      = 1'b0;
        load_val  = '0;

        repeat (3) step();
        check("rst_val", value, 0);
        check("rst_fe", frame_end, 0);
        check("rst_wrap", wrap, 0);
        check("rst_lerr", load_err, 0);
        check("rst_ser", ser_lsb, 0);

        // Up counting from reset
        rst       = 1'b0;
        cnt_start = 1'b1;
        step();
        cnt_start = 1'b0;
        frame("up0", 0, 0, 0);
        frame("up1", 522, 0, 0);
        frame("up2", 1044, 0, 0);
        frame("up3", 1566, 0, 0);
        frame("up4", 35, 1, 0);
        step();
        check("pulse_width_fe", frame_end, 0);
        check("pulse_width_wrap", wrap, 0);

        // Start and stop together: stop wins, frame in flight still completes
        cnt_start = 1'b1;
        cnt_stop  = 1'b1;
        step();
        cnt_start = 1'b0;
        cnt_stop  = 1'b0;
        frame("stop0", 557, 0, 0);
        frame("stop1", 557, 0, 0);
        frame("stop2", 557, 0, 0);

        // Out-of-range load dropped, in-range boundary load accepted
        load     = 1'b1;
        load_val = 12'd2053;
        step();
        load     = 1'b0;
        frame("ldbad", 557, 0, 1);
        step();
        check("ldbad_lerr_clr", load_err, 0);
        check("ldbad_fe_clr", frame_end, 0);
        load     = 1'b1;
        load_val = 12'd2052;
        step();
        load     = 1'b0;
        frame("ldmax", 2052, 0, 0);

        // Load 100 and count down
        dir       = 1'b1;
        load      = 1'b1;
        load_val  = 12'd100;
        cnt_start = 1'b1;
        step();
        load      = 1'b0;
        cnt_start = 1'b0;
        frame("dn0", 100, 0, 0);
        frame("dn1", 1631, 1, 0);
        frame("dn2", 1109, 0, 0);
        frame("dn3", 587, 0, 0);
        frame("dn4", 65, 0, 0);
        frame("dn5", 1596, 1, 0);

        // Clock enable held off mid-frame (slot 5 of 1596 - 522 = 1074, bit 5 = 1)
        repeat (5) step();
        check("pre_pause_ser", ser_lsb, 1);
        pcen_n = 1'b1;
        repeat (50) step();
        check("pause_val", value, 1596);
        check("pause_ser", ser_lsb, 1);
        check("pause_fe", frame_end, 0);
        check("pause_wrap", wrap, 0);
        pcen_n = 1'b0;
        frame("resume", 1074, 0, 0);

        // Reset in slot 5 while counting up from 1566
        dir      = 1'b0;
        load     = 1'b1;
        load_val = 12'd1566;
        step();
        load     = 1'b0;
        frame("ld1566", 1566, 0, 0);
        repeat (5) step();
        rst = 1'b1;
        step();
        check("midrst_val", value, 0);
        check("midrst_fe", frame_end, 0);
        check("midrst_wrap", wrap, 0);
        check("midrst_lerr", load_err, 0);
        rst       = 1'b0;
        cnt_start = 1'b1;
        step();
        cnt_start = 1'b0;
        frame("rs0", 0, 0, 0);
        frame("rs1", 522, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
